// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
// The master drives timing, sensor and button inputs; the slave (the scheduler)
// drives the lamp codes and status flags.
interface traffic_phase_scheduler_if;
   logic       tick;
   logic       ped_btn;
   logic       side_req;
   logic [1:0] light_a;
   logic [1:0] light_b;
   logic       walk;
   logic       ped_pending;
   logic [2:0] phase;

   modport master (
      output tick,
      output ped_btn,
      output side_req,
      input  light_a,
      input  light_b,
      input  walk,
      input  ped_pending,
      input  phase
   );

   modport slave (
      input  tick,
      input  ped_btn,
      input  side_req,
      output light_a,
      output light_b,
      output walk,
      output ped_pending,
      output phase
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection phase scheduler (main road A, side road B, and a
// pedestrian crossing running alongside B). Moore FSM that advances only on
// the 1 Hz tick enable. All lamp outputs decode from registered state, so a
// phase change is visible one clock after the qualifying tick.
module traffic_phase_scheduler #(
   parameter int GREEN_A_MIN = 10,
   parameter int GREEN_B     = 8,
   parameter int YELLOW      = 3,
   parameter int ALL_RED     = 1,
   parameter int WALK        = 5,
   parameter int CNT_W       = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   traffic_phase_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      A_GREEN   = 3'd0,
      A_YELLOW  = 3'd1,
      ALL_RED_1 = 3'd2,
      B_GREEN   = 3'd3,
      B_YELLOW  = 3'd4,
      ALL_RED_2 = 3'd5
   } state_t;

   localparam logic [1:0] LAMP_RED    = 2'b01;
   localparam logic [1:0] LAMP_GREEN  = 2'b10;
   localparam logic [1:0] LAMP_YELLOW = 2'b11;

   // Last counter value of each timed phase; the phase exits on the tick
   // that finds the counter at this value.
   localparam logic [CNT_W-1:0] A_MIN_LAST   = CNT_W'(GREEN_A_MIN - 1);
   localparam logic [CNT_W-1:0] B_GREEN_LAST = CNT_W'(GREEN_B - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] WALK_LIMIT   = CNT_W'(WALK);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ped_sync1_q, ped_sync1_d;
   logic             ped_sync2_q, ped_sync2_d;
   logic             ped_prev_q, ped_prev_d;
   logic             ped_pending_q, ped_pending_d;
   logic             serve_ped_q, serve_ped_d;
   logic             ped_rise;
   logic             enter_b;

   // Button conditioning: two-stage synchroniser plus a previous-value flop,
   // giving a single-clock rise pulse on the third clock after the raw edge.
   always_comb begin
      ped_sync1_d = bus.ped_btn;
      ped_sync2_d = ped_sync1_q;
      ped_prev_d  = ped_sync2_q;
      ped_rise    = ped_sync2_q & ~ped_prev_q;
   end

   // Phase sequencing and phase tick counter; unknown encodings fall back to
   // the all-red clearance that precedes A green.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         A_GREEN: begin
            if (bus.tick) begin
               if (cnt_q == A_MIN_LAST) begin
                  if (bus.side_req | ped_pending_q) begin
                     state_d = A_YELLOW;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         A_YELLOW: begin
            if (bus.tick) begin
               if (cnt_q == YELLOW_LAST) begin
                  state_d = ALL_RED_1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ALL_RED_1: begin
            if (bus.tick) begin
               if (cnt_q == ALL_RED_LAST) begin
                  state_d = B_GREEN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         B_GREEN: begin
            if (bus.tick) begin
               if (cnt_q == B_GREEN_LAST) begin
                  state_d = B_YELLOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         B_YELLOW: begin
            if (bus.tick) begin
               if (cnt_q == YELLOW_LAST) begin
                  state_d = ALL_RED_2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ALL_RED_2: begin
            if (bus.tick) begin
               if (cnt_q == ALL_RED_LAST) begin
                  state_d = A_GREEN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ALL_RED_2;
            cnt_d   = '0;
         end
      endcase
   end

   // Pedestrian request bookkeeping: a new press always wins over the clear
   // at B-green entry, so a press landing on that clock is kept for next cycle.
   always_comb begin
      enter_b       = (state_q == ALL_RED_1) && (state_d == B_GREEN);
      ped_pending_d = ped_pending_q;
      serve_ped_d   = serve_ped_q;
      if (enter_b) begin
         serve_ped_d   = ped_pending_q;
         ped_pending_d = 1'b0;
      end
      if (ped_rise) begin
         ped_pending_d = 1'b1;
      end
   end

   // State, counter and request registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ALL_RED_2;
         cnt_q         <= '0;
         ped_sync1_q   <= 1'b0;
         ped_sync2_q   <= 1'b0;
         ped_prev_q    <= 1'b0;
         ped_pending_q <= 1'b0;
         serve_ped_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ped_sync1_q   <= ped_sync1_d;
         ped_sync2_q   <= ped_sync2_d;
         ped_prev_q    <= ped_prev_d;
         ped_pending_q <= ped_pending_d;
         serve_ped_q   <= serve_ped_d;
      end
   end

   // Lamp decode from registered state only; anything not listed is all red,
   // so the two approaches can never show a non-red aspect together.
   always_comb begin
      bus.light_a = LAMP_RED;
      bus.light_b = LAMP_RED;
      bus.walk    = 1'b0;
      case (state_q)
         A_GREEN:  bus.light_a = LAMP_GREEN;
         A_YELLOW: bus.light_a = LAMP_YELLOW;
         B_GREEN: begin
            bus.light_b = LAMP_GREEN;
            bus.walk    = serve_ped_q && (cnt_q < WALK_LIMIT);
         end
         B_YELLOW: bus.light_b = LAMP_YELLOW;
         default: begin
            bus.light_a = LAMP_RED;
            bus.light_b = LAMP_RED;
         end
      endcase
      bus.ped_pending = ped_pending_q;
      bus.phase       = state_q;
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for the intersection phase scheduler. A behavioural model of the
// phase rules runs alongside the DUT and is compared every clock; directed
// sequences pin the model with hand-computed expectations, then random
// traffic exercises the rest.
module tb_traffic_phase_scheduler;

   localparam int GREEN_A_MIN = 10;
   localparam int GREEN_B     = 8;
   localparam int YELLOW      = 3;
   localparam int ALL_RED     = 1;
   localparam int WALK        = 5;
   localparam int CNT_W       = 5;

   localparam logic [1:0] RED    = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;
   localparam logic [1:0] AMBER  = 2'b11;

   logic clk;
   logic reset_n;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   traffic_phase_scheduler_if bus ();

   traffic_phase_scheduler #(
      .GREEN_A_MIN (GREEN_A_MIN),
      .GREEN_B     (GREEN_B),
      .YELLOW      (YELLOW),
      .ALL_RED     (ALL_RED),
      .WALK        (WALK),
      .CNT_W       (CNT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: phase index 0..5 in road order, ticks spent in the phase,
   // outstanding/served pedestrian request and the last three button samples.
   int       m_phase   = 5;
   int       m_elapsed = 0;
   bit       m_pending = 1'b0;
   bit       m_serve   = 1'b0;
   bit [2:0] m_hist    = 3'b000;
   bit       m_rise;
   int       m_next;

   function automatic int phaseLength(input int p);
      case (p)
         1, 4:    return YELLOW;
         2, 5:    return ALL_RED;
         3:       return GREEN_B;
         default: return GREEN_A_MIN;
      endcase
   endfunction

   function automatic logic [1:0] lampA(input int p);
      if (p == 0) return GREEN;
      if (p == 1) return AMBER;
      return RED;
   endfunction

   function automatic logic [1:0] lampB(input int p);
      if (p == 3) return GREEN;
      if (p == 4) return AMBER;
      return RED;
   endfunction

   // Reference model of the phase rules, advanced once per clock.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase   = 5;
         m_elapsed = 0;
         m_pending = 1'b0;
         m_serve   = 1'b0;
         m_hist    = 3'b000;
      end else begin
         m_rise = m_hist[1] && !m_hist[2];
         m_next = m_phase;
         if (bus.tick) begin
            if (m_phase == 0) begin
               if (m_elapsed >= GREEN_A_MIN - 1) begin
                  if (bus.side_req || m_pending) m_next = 1;
               end else begin
                  m_elapsed++;
               end
            end else if (m_elapsed + 1 >= phaseLength(m_phase)) begin
               m_next = (m_phase + 1) % 6;
            end else begin
               m_elapsed++;
            end
         end
         if (m_next != m_phase) begin
            m_elapsed = 0;
            if (m_next == 3) begin
               m_serve   = m_pending;
               m_pending = 1'b0;
            end
            m_phase = m_next;
         end
         if (m_rise) m_pending = 1'b1;
         m_hist = {m_hist[1:0], bus.ped_btn};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      chk_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-clock comparison against the model, plus the lamp safety invariant.
   always @(negedge clk) begin
      logic [8:0] exp_v;
      logic [8:0] act_v;
      exp_v = {lampA(m_phase), lampB(m_phase),
               (m_phase == 3) && m_serve && (m_elapsed < WALK),
               m_pending, 3'(m_phase)};
      act_v = {bus.light_a, bus.light_b, bus.walk, bus.ped_pending, bus.phase};
      checkOutput("model{la,lb,walk,pend,phase}", 32'(act_v), 32'(exp_v));
      checkOutput("safety_not_both_nonred",
                  32'((bus.light_a != RED) && (bus.light_b != RED)), 32'd0);
   end

   // Drive one clock of inputs; tick is only ever held for that one clock.
   task automatic applyStimulus(input logic t, input logic s, input logic b);
      bus.tick     = t;
      bus.side_req = s;
      bus.ped_btn  = b;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
   endtask

   // Tick (with an idle clock between ticks) until the phase changes.
   task automatic countTicksInPhase(input logic s, output int n);
      logic [2:0] start;
      start = bus.phase;
      n = 0;
      while (bus.phase == start && n < 200) begin
         applyStimulus(1'b1, s, 1'b0);
         applyStimulus(1'b0, s, 1'b0);
         n++;
      end
      if (n >= 200) checkOutput("timeout_leaving_phase", 32'(bus.phase), 32'hFF);
   endtask

   task automatic tickUntil(input logic [2:0] target, input logic s);
      int n;
      n = 0;
      while (bus.phase != target && n < 200) begin
         applyStimulus(1'b1, s, 1'b0);
         applyStimulus(1'b0, s, 1'b0);
         n++;
      end
      if (n >= 200) checkOutput("timeout_reaching_phase", 32'(bus.phase), 32'(target));
   endtask

   initial begin
      int n;
      logic t_prev;
      logic btn;
      logic [1:0] saved_b;

      reset_n      = 1'b0;
      bus.tick     = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_btn  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_phase", 32'(bus.phase), 32'd5);
      checkOutput("reset_light_a", 32'(bus.light_a), 32'(RED));
      checkOutput("reset_light_b", 32'(bus.light_b), 32'(RED));
      checkOutput("reset_walk", 32'(bus.walk), 32'd0);
      checkOutput("reset_pending", 32'(bus.ped_pending), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] one tick into A green, then rest with no demand");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("first_tick_phase", 32'(bus.phase), 32'd0);
      checkOutput("first_tick_light_a", 32'(bus.light_a), 32'(GREEN));
      checkOutput("first_tick_light_b", 32'(bus.light_b), 32'(RED));
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("idle_rest_phase", 32'(bus.phase), 32'd0);

      $display("[TB] side demand drives a full cycle");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("saturated_yield_phase", 32'(bus.phase), 32'd1);
      countTicksInPhase(1'b1, n);
      checkOutput("a_yellow_ticks", 32'(n), 32'd3);
      countTicksInPhase(1'b1, n);
      checkOutput("all_red_1_ticks", 32'(n), 32'd1);
      countTicksInPhase(1'b1, n);
      checkOutput("b_green_ticks", 32'(n), 32'd8);
      countTicksInPhase(1'b1, n);
      checkOutput("b_yellow_ticks", 32'(n), 32'd3);
      countTicksInPhase(1'b1, n);
      checkOutput("all_red_2_ticks", 32'(n), 32'd1);
      countTicksInPhase(1'b1, n);
      checkOutput("a_green_min_ticks", 32'(n), 32'd10);
      tickUntil(3'd0, 1'b0);

      $display("[TB] pedestrian press during A green");
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("pending_after_2clk", 32'(bus.ped_pending), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pending_after_3clk", 32'(bus.ped_pending), 32'd1);
      countTicksInPhase(1'b0, n);
      checkOutput("ped_yield_tick", 32'(n + 3), 32'd10);
      tickUntil(3'd3, 1'b0);
      checkOutput("b_entry_pending_clear", 32'(bus.ped_pending), 32'd0);
      for (int i = 0; i < GREEN_B; i++) begin
         checkOutput("b_green_walk", 32'(bus.walk), 32'(i < WALK));
         applyStimulus(1'b1, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("after_b_green_phase", 32'(bus.phase), 32'd4);

      $display("[TB] press lands on the B green entry clock");
      tickUntil(3'd2, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("coincide_phase", 32'(bus.phase), 32'd3);
      checkOutput("coincide_pending_kept", 32'(bus.ped_pending), 32'd1);
      checkOutput("coincide_walk", 32'(bus.walk), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] tick held low mid B green");
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      saved_b = bus.light_b;
      repeat (100) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("frozen_phase", 32'(bus.phase), 32'd3);
      checkOutput("frozen_light_b", 32'(bus.light_b), 32'(saved_b));
      countTicksInPhase(1'b0, n);
      checkOutput("b_green_remaining", 32'(n), 32'd6);
      tickUntil(3'd3, 1'b0);
      checkOutput("served_again_walk", 32'(bus.walk), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_reset_pending", 32'(bus.ped_pending), 32'd1);
      checkOutput("pre_reset_walk", 32'(bus.walk), 32'd1);

      $display("[TB] asynchronous reset mid B green");
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_walk", 32'(bus.walk), 32'd0);
      checkOutput("async_reset_light_a", 32'(bus.light_a), 32'(RED));
      checkOutput("async_reset_light_b", 32'(bus.light_b), 32'(RED));
      checkOutput("async_reset_pending", 32'(bus.ped_pending), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("post_reset_a_green", 32'(bus.phase), 32'd0);

      $display("[TB] randomized traffic");
      t_prev = 1'b0;
      btn    = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         logic t;
         t = !t_prev && ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) btn = ~btn;
         applyStimulus(t, ($urandom_range(0, 9) == 0), btn);
         t_prev = t;
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
